// File: rtl/spiking_neuron_nin_pkg.sv
// spiking_pkg: shared types, command decoding helpers, default kernel and
// sum/clamp geometry for the N-input spiking neuron.
package spiking_pkg;

  // Age counters are wide enough for STATE_GOOD_MAX up to 30.
  localparam int AGE_W = 5;
  typedef logic [AGE_W-1:0] age_t;

  // Age value meaning "no spike seen recently"; the kernel weight here is zero.
  function automatic age_t state_null(input int good_max);
    return age_t'(good_max + 32'sd1);
  endfunction

  // Width of cmd_arg, weights and bias.
  function automatic int float_width(input int int_w);
    return 32'sd2 * int_w;
  endfunction

  // Command codes. Codes 1..N address the per-input weights.
  function automatic int cmd_delivery(input int n);
    return n + 32'sd1;
  endfunction

  function automatic int cmd_bias(input int n);
    return n + 32'sd2;
  endfunction

  function automatic int cmd_kernel(input int n);
    return n + 32'sd3;
  endfunction

  function automatic int cmd_clear(input int cmd_w);
    return (32'sd1 << cmd_w) - 32'sd3;
  endfunction

  // Default time kernel: floor(INT_MAX * {0.7, 1.0, 0.6, 0.3, 0.1}).
  function automatic int kernel_default(input int idx, input int int_w);
    int m;
    m = (32'sd1 << int_w) - 32'sd1;
    case (idx)
      0:       return (m * 32'sd7) / 32'sd10;
      1:       return m;
      2:       return (m * 32'sd6) / 32'sd10;
      3:       return (m * 32'sd3) / 32'sd10;
      4:       return m / 32'sd10;
      default: return 32'sd0;
    endcase
  endfunction

  // Full-precision signed sum width: products are 3*I bits, plus growth for
  // N weighted terms, bias and self-inhibition, plus the sign.
  function automatic int sum_width(input int int_w, input int n);
    return 32'sd3 * int_w + $clog2(n + 32'sd2) + 32'sd1;
  endfunction

  // Bit range of the sum that becomes the integer potential.
  function automatic int clamp_lsb(input int int_w);
    return int_w;
  endfunction

  function automatic int clamp_msb(input int int_w);
    return 32'sd2 * int_w - 32'sd1;
  endfunction

endpackage

// File: rtl/spiking_neuron_nin_if.sv
// Configuration bus, spike inputs and neuron outputs bundled for one neuron.
interface spiking_neuron_nin_if
  import spiking_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int CMD_WIDTH    = 8,
  parameter int INT_WIDTH    = 8,
  parameter int INPUTS_COUNT = 4
);
  logic [ADDR_WIDTH-1:0]            addr;
  logic [CMD_WIDTH-1:0]             cmd;
  logic [float_width(INT_WIDTH)-1:0] cmd_arg;
  logic [INPUTS_COUNT-1:0]          in;
  logic                             out;
  logic [INT_WIDTH-1:0]             potential;

  modport master (output addr, cmd, cmd_arg, in, input out, potential);
  modport slave  (input addr, cmd, cmd_arg, in, output out, potential);
endinterface

// File: rtl/spiking_neuron_nin_age_tracker.sv
// spike_age_tracker: counts ticks since the last spike, saturating to the
// null age once the age passes STATE_GOOD_MAX.
module spike_age_tracker
  import spiking_pkg::*;
#(
  parameter int STATE_GOOD_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic spike_i,
  input  logic clear_i,
  output age_t age_aged_o
);
  localparam age_t GOOD_MAX_A = age_t'(STATE_GOOD_MAX);
  localparam age_t NULL_AGE   = state_null(STATE_GOOD_MAX);

  age_t age_q;
  age_t age_d;

  // Age after one tick without a spike; exported so the caller can decide on
  // the spike without a combinational loop through this counter.
  always_comb begin
    if (age_q < GOOD_MAX_A) begin
      age_aged_o = age_q + age_t'(1);
    end else begin
      age_aged_o = NULL_AGE;
    end
  end

  // Next age: clear wins, a tick either restarts or ages, otherwise hold.
  always_comb begin
    age_d = age_q;
    if (clear_i) begin
      age_d = NULL_AGE;
    end else if (tick_i) begin
      age_d = spike_i ? age_t'(0) : age_aged_o;
    end else begin
      age_d = age_q;
    end
  end

  // Age register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q <= NULL_AGE;
    end else begin
      age_q <= age_d;
    end
  end
endmodule

// File: rtl/spiking_neuron_nin.sv
// spiking_neuron_nin: N-input spiking neuron with per-input spike ages, time
// kernel weighting, self-inhibition, bias, saturating potential, threshold
// fire and programmable delivery delay.
// Optional: SPIKING_NEURON_KERNEL_PROG_EN makes the kernel writable (cmd N+3).
module spiking_neuron_nin
  import spiking_pkg::*;
#(
  parameter int NEURON_ID           = -1,
  parameter int INPUTS_COUNT        = 4,
  parameter int ADDR_WIDTH          = 8,
  parameter int CMD_WIDTH           = 8,
  parameter int INT_WIDTH           = 8,
  parameter int STATE_GOOD_MAX      = 4,
  parameter int OUT_BARRIER         = ((1 << INT_WIDTH) - 1) / 2,
  parameter int COMPENSATION_WEIGHT = ((1 << INT_WIDTH) - 1) * INPUTS_COUNT
) (
  input logic              clk,
  input logic              rst,
  spiking_neuron_nin_if.slave bus
);
  localparam int N       = INPUTS_COUNT;
  localparam int FW      = float_width(INT_WIDTH);
  localparam int SUM_W   = sum_width(INT_WIDTH, N);
  localparam int C_LSB   = clamp_lsb(INT_WIDTH);
  localparam int C_MSB   = clamp_msb(INT_WIDTH);
  localparam int INT_MAX = (1 << INT_WIDTH) - 1;
  localparam int KN      = STATE_GOOD_MAX + 1;

  localparam logic [ADDR_WIDTH-1:0] MY_ADDR   = ADDR_WIDTH'(NEURON_ID);
  localparam logic [CMD_WIDTH-1:0]  CMD_DELIV = CMD_WIDTH'(cmd_delivery(N));
  localparam logic [CMD_WIDTH-1:0]  CMD_BIAS  = CMD_WIDTH'(cmd_bias(N));
  localparam logic [CMD_WIDTH-1:0]  CMD_CLR   = CMD_WIDTH'(cmd_clear(CMD_WIDTH));
  localparam logic signed [SUM_W-1:0] COMP_W  = SUM_W'(COMPENSATION_WEIGHT);
  localparam logic [INT_WIDTH:0]    BARRIER   = (INT_WIDTH + 1)'(OUT_BARRIER);
  localparam logic [FW-1:0]         W_RESET   = FW'(INT_MAX / N);
  localparam logic [INT_WIDTH-1:0]  DT_RESET  = INT_WIDTH'(1);

  logic signed [FW-1:0]  weight_q [N];
  logic signed [FW-1:0]  weight_d [N];
  logic signed [FW-1:0]  bias_q, bias_d;
  logic [INT_WIDTH-1:0]  delivery_time_q, delivery_time_d;
  logic [INT_WIDTH-1:0]  delivery_cnt_q, delivery_cnt_d;
  logic [INT_WIDTH-1:0]  potential_q, potential_d;
  logic                  out_q, out_d;

  logic [INT_WIDTH-1:0]  kern_s [KN];
  age_t                  age_aged_s [N+1];
  age_t                  eval_age_s [N+1];
  logic [INT_WIDTH-1:0]  k_s [N+1];
  logic                  tick_s, clear_s, hit_s, fire_s, fire_evt_s;
  logic signed [SUM_W-1:0] sum_s, acc_s, k_ext_s, w_ext_s, bias_ext_s;
  logic [INT_WIDTH-1:0]  clamp_s;

  // Bus decode: cmd 0 is a tick, clear ignores the address.
  always_comb begin
    tick_s  = (bus.cmd == '0);
    clear_s = (bus.cmd == CMD_CLR);
    hit_s   = (bus.addr == MY_ADDR);
  end

  for (genvar g = 0; g < N; g++) begin : g_in_age
    spike_age_tracker #(.STATE_GOOD_MAX(STATE_GOOD_MAX)) u_age (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_s),
      .spike_i   (bus.in[g]),
      .clear_i   (clear_s),
      .age_aged_o(age_aged_s[g])
    );
  end

  // The output age restarts when the neuron fires on an evaluating tick.
  spike_age_tracker #(.STATE_GOOD_MAX(STATE_GOOD_MAX)) u_out_age (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick_s),
    .spike_i   (fire_evt_s),
    .clear_i   (clear_s),
    .age_aged_o(age_aged_s[N])
  );

  // Ages the evaluation sees: inputs include this tick's spikes, the output
  // age is the pre-fire aged value.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eval_age_s[i] = bus.in[i] ? age_t'(0) : age_aged_s[i];
    end
    eval_age_s[N] = age_aged_s[N];
  end

  // Kernel lookup per age; ages outside the table (null) weigh zero.
  always_comb begin
    for (int i = 0; i <= N; i++) begin
      k_s[i] = '0;
      for (int j = 0; j < KN; j++) begin
        if (eval_age_s[i] == age_t'(j)) begin
          k_s[i] = kern_s[j];
        end else begin
          k_s[i] = k_s[i];
        end
      end
    end
  end

  // Full-precision signed sum: -K[out]*COMP + bias*2^I + sum K[i]*w[i].
  always_comb begin
    acc_s      = '0;
    k_ext_s    = {{(SUM_W-INT_WIDTH){1'b0}}, k_s[N]};
    w_ext_s    = '0;
    bias_ext_s = {{(SUM_W-FW){bias_q[FW-1]}}, bias_q};
    acc_s      = acc_s - k_ext_s * COMP_W;
    acc_s      = acc_s + (bias_ext_s <<< INT_WIDTH);
    for (int i = 0; i < N; i++) begin
      k_ext_s = {{(SUM_W-INT_WIDTH){1'b0}}, k_s[i]};
      w_ext_s = {{(SUM_W-FW){weight_q[i][FW-1]}}, weight_q[i]};
      acc_s   = acc_s + k_ext_s * w_ext_s;
    end
    sum_s = acc_s;
  end

  // Clamp to the integer potential and compare against the firing barrier.
  always_comb begin
    if (sum_s[SUM_W-1]) begin
      clamp_s = '0;
    end else if (|sum_s[SUM_W-2:FW]) begin
      clamp_s = INT_WIDTH'(INT_MAX);
    end else begin
      clamp_s = sum_s[C_MSB:C_LSB];
    end
    fire_s     = ({1'b0, clamp_s} > BARRIER);
    fire_evt_s = tick_s && (delivery_cnt_q == '0) && fire_s;
  end

  // Next state: clear, tick (countdown or evaluate), or configuration write.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      weight_d[i] = weight_q[i];
    end
    bias_d          = bias_q;
    delivery_time_d = delivery_time_q;
    delivery_cnt_d  = delivery_cnt_q;
    potential_d     = potential_q;
    out_d           = out_q;
    if (clear_s) begin
      out_d          = 1'b0;
      delivery_cnt_d = '0;
      potential_d    = '0;
    end else if (tick_s) begin
      if (delivery_cnt_q != '0) begin
        out_d          = (delivery_cnt_q == INT_WIDTH'(1));
        delivery_cnt_d = delivery_cnt_q - INT_WIDTH'(1);
      end else begin
        potential_d = clamp_s;
        out_d       = fire_s && (delivery_time_q == '0);
        if (fire_s && (delivery_time_q != '0)) begin
          delivery_cnt_d = delivery_time_q;
        end else begin
          delivery_cnt_d = delivery_cnt_q;
        end
      end
    end else if (hit_s) begin
      for (int i = 0; i < N; i++) begin
        if (bus.cmd == CMD_WIDTH'(i + 1)) begin
          weight_d[i] = bus.cmd_arg;
        end else begin
          weight_d[i] = weight_q[i];
        end
      end
      if (bus.cmd == CMD_DELIV) begin
        delivery_time_d = bus.cmd_arg[INT_WIDTH-1:0];
      end else if (bus.cmd == CMD_BIAS) begin
        bias_d = bus.cmd_arg;
      end else begin
        bias_d = bias_q;
      end
    end else begin
      out_d = out_q;
    end
  end

`ifdef SPIKING_NEURON_KERNEL_PROG_EN
  localparam logic [CMD_WIDTH-1:0] CMD_KERN = CMD_WIDTH'(cmd_kernel(N));

  logic [INT_WIDTH-1:0] kern_q [KN];
  logic [INT_WIDTH-1:0] kern_d [KN];

  // Kernel write: index in the upper half of cmd_arg, out-of-range ignored.
  always_comb begin
    for (int j = 0; j < KN; j++) begin
      kern_d[j] = kern_q[j];
      if (hit_s && !clear_s && (bus.cmd == CMD_KERN) &&
          (bus.cmd_arg[FW-1:INT_WIDTH] == INT_WIDTH'(j))) begin
        kern_d[j] = bus.cmd_arg[INT_WIDTH-1:0];
      end else begin
        kern_d[j] = kern_q[j];
      end
    end
  end

  // Kernel register file, reset to the default shape.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < KN; j++) begin
        kern_q[j] <= INT_WIDTH'(kernel_default(j, INT_WIDTH));
      end
    end else begin
      for (int j = 0; j < KN; j++) begin
        kern_q[j] <= kern_d[j];
      end
    end
  end

  // Evaluation reads the programmed kernel.
  always_comb begin
    for (int j = 0; j < KN; j++) begin
      kern_s[j] = kern_q[j];
    end
  end
`else
  // Evaluation reads the fixed default kernel.
  always_comb begin
    for (int j = 0; j < KN; j++) begin
      kern_s[j] = INT_WIDTH'(kernel_default(j, INT_WIDTH));
    end
  end
`endif

  // Neuron state and configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= W_RESET;
      end
      bias_q          <= '0;
      delivery_time_q <= DT_RESET;
      delivery_cnt_q  <= '0;
      potential_q     <= '0;
      out_q           <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= weight_d[i];
      end
      bias_q          <= bias_d;
      delivery_time_q <= delivery_time_d;
      delivery_cnt_q  <= delivery_cnt_d;
      potential_q     <= potential_d;
      out_q           <= out_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.potential = potential_q;
endmodule
